mem_uart_tx: RTL and testbench

Memory-mapped serial transmitter that answers on the processor's memory address/data bus. It decodes a 4-byte window, accepts byte writes into a TX FIFO, and serialises the bytes onto TXD as 8N1 frames. Status and divisor registers are readable over the same bus. It is the responder counterpart to the processor's memory-bus initiator and sits beside the ROM/RAM memory block, sharing its ADDR_IN/DATA_IN/WE_bar/OE_bar signalling.

---
 rtl/mem_uart_pkg.sv | 22 ++
 rtl/mem_uart_tx_if.sv | 15 +
 rtl/sync_fifo.sv | 61 ++++++
 rtl/mem_uart_tx.sv | 184 ++++++++++++++++++
 tb/tb_mem_uart_tx.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit positions and transmit FSM encoding.
package mem_uart_pkg;

   localparam logic [1:0] OFF_TXDATA  = 2'd0;
   localparam logic [1:0] OFF_STATUS  = 2'd1;
   localparam logic [1:0] OFF_DIVISOR = 2'd2;
   localparam logic [1:0] OFF_RSVD    = 2'd3;

   localparam int ST_FULL     = 0;
   localparam int ST_EMPTY    = 1;
   localparam int ST_BUSY     = 2;
   localparam int ST_OVERFLOW = 3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/mem_uart_tx_if.sv
// Processor memory-bus signalling shared with the ROM/RAM block; the
// initiator drives address/data/strobes, the responder returns read data.
interface mem_uart_tx_if;
   logic [15:0] ADDR_IN;
   logic [7:0]  DATA_IN;
   logic        WE_bar;
   logic        OE_bar;
   logic [7:0]  DATA_OUT;
   logic        ASSERT_bar;

   modport master (output ADDR_IN, DATA_IN, WE_bar, OE_bar,
                   input  DATA_OUT, ASSERT_bar);
   modport slave  (input  ADDR_IN, DATA_IN, WE_bar, OE_bar,
                   output DATA_OUT, ASSERT_bar);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a push while full is accepted when a pop frees the
// head slot on the same edge.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int                    DEPTH   = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
   localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
   localparam logic [DEPTH_LOG2:0]   CNT_MAX = DEPTH;

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CNT_MAX);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem_q[rd_ptr_q];

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/mem_uart_tx.sv
// Memory-mapped 8N1 transmitter: 4-byte register window on the processor bus,
// TX FIFO, and a bit-period down-counter driven serialiser.
//
//   state   | meaning
//   S_IDLE  | line high, waiting for a queued byte
//   S_START | start bit (low) for DIVISOR+1 clocks
//   S_DATA  | eight data bits, LSB first
//   S_STOP  | stop bit (high); chains straight into the next frame
module mem_uart_tx
   import mem_uart_pkg::*;
#(
   parameter logic [15:0] BASE_ADDR       = 16'hFF00,
   parameter int          FIFO_DEPTH_LOG2 = 2,
   parameter logic [7:0]  DIVISOR_RESET   = 8'd0,
   parameter int          DELAY_RISE      = 0,
   parameter int          DELAY_FALL      = 0
) (
   input  logic          CLK,
   input  logic          RST,
   mem_uart_tx_if.slave  bus,
   output logic          TXD,
   output logic          IRQ_bar
);
   // Delays only shape behavioural models of the read path; hardware is zero-delay.
   if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
      $error("BASE_ADDR must be 4-byte aligned");
   end
   if ((DELAY_RISE < 0) || (DELAY_FALL < 0)) begin : g_bad_delay
      $error("DELAY_RISE/DELAY_FALL must be non-negative");
   end

   tx_state_e  state_q, state_d;
   logic [7:0] cnt_q, cnt_d, shift_q, shift_d, div_lat_q, div_lat_d;
   logic [7:0] div_q, div_d, status;
   logic [2:0] idx_q, idx_d;
   logic       ovf_q, ovf_d, wr_hold_q, wr_hold_d, txd_q, txd_d, irq_q, irq_d;
   logic       sel, wr_commit, fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [1:0] off;
   logic [7:0] fifo_dout;

   assign sel       = (bus.ADDR_IN[15:2] == BASE_ADDR[15:2]);
   assign off       = bus.ADDR_IN[1:0];
   assign wr_commit = sel & ~bus.WE_bar & ~wr_hold_q;
   assign bus.ASSERT_bar = ~(sel & ~bus.OE_bar);

   always_comb begin
      status              = '0;
      status[ST_FULL]     = fifo_full;
      status[ST_EMPTY]    = fifo_empty;
      status[ST_BUSY]     = (state_q != S_IDLE);
      status[ST_OVERFLOW] = ovf_q;
   end

   always_comb begin
      bus.DATA_OUT = 8'h00;
      if (!bus.ASSERT_bar) begin
         case (off)
            OFF_STATUS:  bus.DATA_OUT = status;
            OFF_DIVISOR: bus.DATA_OUT = div_q;
            OFF_RSVD:    bus.DATA_OUT = 8'h00;
            default:     bus.DATA_OUT = 8'h00;
         endcase
      end
   end

   // A held strobe writes once; re-arming needs WE_bar sampled high.
   always_comb begin
      wr_hold_d = wr_hold_q;
      div_d     = div_q;
      ovf_d     = ovf_q;
      fifo_push = 1'b0;
      if (bus.WE_bar)     wr_hold_d = 1'b0;
      else if (wr_commit) wr_hold_d = 1'b1;
      if (wr_commit) begin
         case (off)
            OFF_TXDATA: begin
               fifo_push = 1'b1;
               if (fifo_full && !fifo_pop) ovf_d = 1'b1;
            end
            OFF_STATUS:  ovf_d = 1'b0;
            OFF_DIVISOR: div_d = bus.DATA_IN;
            default:     ;
         endcase
      end
   end

   sync_fifo #(.WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
      .clk   (CLK),
      .rst   (RST),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (bus.DATA_IN),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      idx_d     = idx_q;
      shift_d   = shift_q;
      div_lat_d = div_lat_q;
      fifo_pop  = 1'b0;
      txd_d     = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               shift_d   = fifo_dout;
               cnt_d     = div_q;
               div_lat_d = div_q;
               idx_d     = '0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (cnt_q == '0) begin
               cnt_d   = div_lat_q;
               state_d = S_DATA;
            end else cnt_d = cnt_q - 8'd1;
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               cnt_d = div_lat_q;
               if (idx_q == 3'd7) state_d = S_STOP;
               else begin
                  idx_d   = idx_q + 3'd1;
                  shift_d = shift_q >> 1;
               end
            end else cnt_d = cnt_q - 8'd1;
         end
         S_STOP: begin
            if (cnt_q == '0) begin
               if (!fifo_empty) begin
                  fifo_pop  = 1'b1;
                  shift_d   = fifo_dout;
                  cnt_d     = div_q;
                  div_lat_d = div_q;
                  idx_d     = '0;
                  state_d   = S_START;
               end else state_d = S_IDLE;
            end else cnt_d = cnt_q - 8'd1;
         end
         default: state_d = S_IDLE;
      endcase
      case (state_d)
         S_START: txd_d = 1'b0;
         S_DATA:  txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
      irq_d = ~(fifo_empty & (state_q == S_IDLE));
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         div_lat_q <= DIVISOR_RESET;
         div_q     <= DIVISOR_RESET;
         ovf_q     <= 1'b0;
         wr_hold_q <= 1'b0;
         txd_q     <= 1'b1;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shift_q   <= shift_d;
         div_lat_q <= div_lat_d;
         div_q     <= div_d;
         ovf_q     <= ovf_d;
         wr_hold_q <= wr_hold_d;
         txd_q     <= txd_d;
         irq_q     <= irq_d;
      end
   end

   assign TXD     = txd_q;
   assign IRQ_bar = irq_q;

endmodule

// File: tb/tb_mem_uart_tx.sv
// Directed bench for mem_uart_tx: TXD is logged once per clock and frames are
// checked against hand-computed bit patterns at known clock offsets.
module tb_mem_uart_tx;
   logic CLK = 1'b0;
   logic RST;
   logic TXD, IRQ_bar;

   mem_uart_tx_if bus_if ();

   mem_uart_tx u_dut (
      .CLK     (CLK),
      .RST     (RST),
      .bus     (bus_if.slave),
      .TXD     (TXD),
      .IRQ_bar (IRQ_bar)
   );

   always #5 CLK = ~CLK;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   logic txd_log [0:4095];

   always @(posedge CLK) cyc <= cyc + 1;
   always @(negedge CLK) if (cyc < 4096) txd_log[cyc] = TXD;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [7:0] d, output int c);
      @(negedge CLK);
      bus_if.ADDR_IN = a;
      bus_if.DATA_IN = d;
      bus_if.WE_bar  = 1'b0;
      @(negedge CLK);
      c = cyc;
      bus_if.WE_bar = 1'b1;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic ab);
      @(negedge CLK);
      bus_if.ADDR_IN = a;
      bus_if.OE_bar  = 1'b0;
      #1;
      d  = bus_if.DATA_OUT;
      ab = bus_if.ASSERT_bar;
      bus_if.OE_bar = 1'b1;
   endtask

   task automatic wait_cyc(input int target);
      int g = 0;
      while (cyc < target) begin
         @(negedge CLK);
         g++;
         if (g > 2000) begin
            chk("wait_timeout", 64'(cyc), 64'(target));
            return;
         end
      end
   endtask

   function automatic logic [63:0] slice(input int base, input int n);
      logic [63:0] v = '0;
      for (int k = 0; k < n; k++) v[k] = txd_log[base + k];
      return v;
   endfunction

   // Byte from a frame starting at base, sampling the last clock of each bit.
   function automatic logic [7:0] decode(input int base, input int per);
      logic [7:0] b;
      for (int j = 0; j < 8; j++) b[j] = txd_log[base + per * (1 + j) + per - 1];
      return b;
   endfunction

   function automatic logic all_ones(input int a, input int b);
      logic ok = 1'b1;
      for (int k = a; k < b; k++) if (txd_log[k] !== 1'b1) ok = 1'b0;
      return ok;
   endfunction

   logic [7:0]  rd;
   logic        ab;
   int          w, e0, h, r, tmp;
   logic [9:0]  pat;
   logic [63:0] exp_v, got_v, starts, stops;

   initial begin
      RST = 1'b1;
      bus_if.ADDR_IN = 16'h0000;
      bus_if.DATA_IN = 8'h00;
      bus_if.WE_bar  = 1'b1;
      bus_if.OE_bar  = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;

      // reset / idle
      chk("rst_txd", TXD, 1'b1);
      chk("rst_irq", IRQ_bar, 1'b0);
      bus_read(16'h0000, rd, ab);
      chk("unsel_assert", ab, 1'b1);
      chk("unsel_data", rd, 8'h00);
      bus_read(16'hFF01, rd, ab);
      chk("rst_status", rd, 8'h02);
      chk("sel_assert", ab, 1'b0);
      bus_read(16'hFF02, rd, ab);
      chk("rst_divisor", rd, 8'h00);
      bus_read(16'hFF03, rd, ab);
      chk("rsvd_read", rd, 8'h00);

      // single A5 frame at 4 clocks per bit
      bus_write(16'hFF02, 8'h03, tmp);
      bus_read(16'hFF02, rd, ab);
      chk("div_rw", rd, 8'h03);
      bus_write(16'hFF00, 8'hA5, w);
      repeat (10) @(negedge CLK);
      bus_read(16'hFF01, rd, ab);
      chk("busy_status", rd, 8'h06);
      chk("busy_irq", IRQ_bar, 1'b1);
      wait_cyc(w + 52);
      chk("latency_idle", txd_log[w], 1'b1);
      chk("latency_fall", txd_log[w + 1], 1'b0);
      pat   = 10'b1101001010;
      exp_v = '0;
      for (int k = 0; k < 40; k++) exp_v[k] = pat[k / 4];
      chk("a5_frame", slice(w + 1, 40), exp_v);
      chk("a5_after", txd_log[w + 41], 1'b1);
      chk("a5_irq_low", IRQ_bar, 1'b0);
      bus_read(16'hFF01, rd, ab);
      chk("a5_status", rd, 8'h02);

      // fill FIFO during a frame, overflow, clear, back-to-back frames
      bus_write(16'hFF02, 8'h01, tmp);
      bus_write(16'hFF00, 8'h01, e0);
      bus_write(16'hFF00, 8'h02, tmp);
      bus_write(16'hFF00, 8'h03, tmp);
      bus_write(16'hFF00, 8'h04, tmp);
      bus_write(16'hFF00, 8'h05, tmp);
      bus_read(16'hFF01, rd, ab);
      chk("full_status", rd, 8'h05);
      bus_write(16'hFF00, 8'hFF, tmp);
      bus_read(16'hFF01, rd, ab);
      chk("ovf_status", rd, 8'h0D);
      bus_write(16'hFF01, 8'h00, tmp);
      bus_read(16'hFF01, rd, ab);
      chk("ovf_clear", rd, 8'h05);
      bus_read(16'hFF02, rd, ab);
      chk("div1_read", rd, 8'h01);
      wait_cyc(e0 + 140);
      got_v  = '0;
      starts = '0;
      stops  = '0;
      for (int f = 0; f < 5; f++) begin
         got_v[8*f +: 8]  = decode(e0 + 1 + 20 * f, 2);
         starts[2*f]      = txd_log[e0 + 1 + 20 * f];
         starts[2*f + 1]  = txd_log[e0 + 2 + 20 * f];
         stops[2*f]       = txd_log[e0 + 19 + 20 * f];
         stops[2*f + 1]   = txd_log[e0 + 20 + 20 * f];
      end
      chk("b2b_bytes", got_v, 64'h05_04_03_02_01);
      chk("b2b_starts", starts, 64'h0);
      chk("b2b_stops", stops, 64'h3FF);
      chk("no_ff_sent", all_ones(e0 + 101, e0 + 135), 1'b1);
      bus_read(16'hFF01, rd, ab);
      chk("b2b_status", rd, 8'h02);

      // held write strobe sends one frame
      bus_write(16'hFF02, 8'h00, tmp);
      @(negedge CLK);
      bus_if.ADDR_IN = 16'hFF00;
      bus_if.DATA_IN = 8'h55;
      bus_if.WE_bar  = 1'b0;
      @(negedge CLK);
      h = cyc;
      repeat (4) @(negedge CLK);
      bus_if.WE_bar = 1'b1;
      wait_cyc(h + 45);
      chk("held_start", txd_log[h + 1], 1'b0);
      chk("held_byte", decode(h + 1, 1), 8'h55);
      chk("held_stop", txd_log[h + 10], 1'b1);
      chk("held_single", all_ones(h + 11, h + 41), 1'b1);

      // reset mid-DATA with two bytes queued
      bus_write(16'hFF02, 8'h03, tmp);
      bus_write(16'hFF00, 8'h00, w);
      bus_write(16'hFF00, 8'h00, tmp);
      bus_write(16'hFF00, 8'h00, tmp);
      wait_cyc(w + 14);
      RST = 1'b1;
      @(negedge CLK);
      r = cyc;
      RST = 1'b0;
      repeat (60) @(negedge CLK);
      chk("pre_rst_low", txd_log[r - 1], 1'b0);
      chk("rst_txd_high", txd_log[r], 1'b1);
      chk("rst_no_frames", all_ones(r, r + 55), 1'b1);
      chk("rst_irq_low", IRQ_bar, 1'b0);
      bus_read(16'hFF01, rd, ab);
      chk("rst_mid_status", rd, 8'h02);
      bus_read(16'hFF02, rd, ab);
      chk("rst_mid_div", rd, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
